freq_count_fsm: RTL and testbench
=================================

// Module: freq_count_fsm
// PURPOSE
//  Measures the frequency of an external square wave. It counts rising edges over a fixed gate
//  window of clk cycles, then converts the count to two BCD digits by repeated subtraction.
//  Sits directly upstream of the seven-segment display driver and feeds its
//  ten_count/unit_count/load inputs. The result is displayed in units of edges per window (0-99).
// PARAMETERS
//  UPDATE_PERIOD  1200  gate window length in clk cycles (>=2)
//  CNT_W          7     raw edge counter width; saturates at 99, so must be >=7
// PORTS
//  clk         in   1   system clock; all logic on posedge
//  reset       in   1   asynchronous, active-low reset (asserts immediately, independent of clk)
//  signal      in   1   asynchronous input waveform to measure
//  ten_count   out  4   BCD tens digit of last completed measurement
//  unit_count  out  4   BCD units digit of last completed measurement
//  load        out  1   one-cycle strobe; ten/unit values valid and new in that cycle
//  overflow    out  1   (only with FREQ_OVERFLOW_EN) raw count exceeded 99 in last window
// BEHAVIOUR
//  Reset (reset=0): state=COUNT; timer, edge_cnt, tens accumulator, sync flops cleared;
//   ten_count=0, unit_count=0, load=0, overflow=0. Reset mid-window or mid-conversion aborts
//   everything; the first window after release starts at timer=0.
//  Input path: 2-flop synchroniser sig_s1->sig_s2, plus prev flop sig_q.
//   rise = sig_s2 & ~sig_q. Pin-to-rise latency is 2-3 clk. Pulses shorter than a clk period
//   may be missed; that is acceptable.
//  FSM states (registered):
//   COUNT: timer++ every cycle. If rise, then edge_cnt = min(edge_cnt+1, 99) (saturating).
//    When timer==UPDATE_PERIOD-1, a rise in that same cycle is still counted.
//    Next state is TENS and timer<=0. The window is exactly UPDATE_PERIOD cycles.
//   TENS: one subtraction per cycle. If edge_cnt>=10, then edge_cnt-=10 and tens++.
//    Else go to UNITS. Rises are ignored; sig_q still tracks.
//   UNITS: ten_count<=tens; unit_count<=edge_cnt[3:0]; load<=1. Clear edge_cnt and tens.
//    Next state is COUNT.
//  load is registered. It is high for exactly 1 cycle per window: the cycle after UNITS,
//   aligned with the new outputs. Otherwise load=0.
//  Outputs hold their values between strobes. The downstream stage latches them on load.
//  Latency from window end to load high = (tens+1) TENS cycles + 1 UNITS cycle + 1 register
//   = tens+3 cycles (max 12). Edges in this gap are dropped.
//  Period between load strobes = UPDATE_PERIOD + tens + 2 cycles. This is not constant.
//  Arithmetic: edge_cnt never exceeds 99, so tens<=9 and the remainder is <=9.
//   BCD outputs are never >9.
// CONFIGURATION
//  FREQ_OVERFLOW_EN defined: adds the overflow port and a sticky ovf_raw flag. ovf_raw is set
//   when a rise arrives while edge_cnt==99 in COUNT. overflow<=ovf_raw in UNITS, alongside the
//   digits. ovf_raw is cleared at window start and by reset.
//  FREQ_OVERFLOW_EN undefined: no port, no flag. Saturation at 99 still applies.
// TESTING
//  1 Reset: hold reset=0 with signal toggling -> all outputs 0, no load; release -> first load
//    after UPDATE_PERIOD+2..+12 cycles.
//  2 42 rises in one window (UPDATE_PERIOD=1200) -> load 1 cycle, ten_count=4, unit_count=2,
//    overflow=0; load exactly 4+3 cycles after the window's last cycle.
//  3 signal stuck high or low for a window -> ten=0, unit=0, load still pulses.
//    Next window with 7 rises -> 0/7.
//  4 150 rises -> ten=9, unit=9; with FREQ_OVERFLOW_EN overflow=1.
//    The following window with 10 rises -> 1/0, overflow=0.
//  5 A rise on timer==UPDATE_PERIOD-1 is counted. A rise during TENS/UNITS is not.
//    Total 10 rises -> 1/0.
//  6 Assert reset during the TENS of a 95-count window -> outputs 0, no load.
//    After release, 20 rises -> 2/0.

Source files
------------

// File: rtl/freq_count_fsm.sv
// ============================================================================
// Module  : freq_count_fsm
// Desc    : Counts rising edges of an asynchronous input over a fixed gate
//           window, then converts the count to two BCD digits. Defining
//           FREQ_OVERFLOW_EN adds an overflow output flag.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module freq_count_fsm #(
  parameter int UPDATE_PERIOD = 1200,
  parameter int CNT_W         = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       signal,
  output logic [3:0] ten_count,
  output logic [3:0] unit_count,
  output logic       load
`ifdef FREQ_OVERFLOW_EN
  ,
  output logic       overflow
`endif
);

  localparam int                 c_timer_w    = $clog2(UPDATE_PERIOD);
  localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(UPDATE_PERIOD - 1);
  localparam logic [CNT_W-1:0]   c_cnt_max    = CNT_W'(99);
  localparam logic [CNT_W-1:0]   c_cnt_ten    = CNT_W'(10);

  typedef enum logic [1:0] {
    ST_COUNT = 2'd0,
    ST_TENS  = 2'd1,
    ST_UNITS = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [c_timer_w-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic [3:0]             tens_q, tens_d;
  logic [3:0]             ten_count_q, ten_count_d;
  logic [3:0]             unit_count_q, unit_count_d;
  logic                   load_q, load_d;
  logic                   sig_s1_q, sig_s2_q, sig_q;
  logic                   w_rise;
`ifdef FREQ_OVERFLOW_EN
  logic                   ovf_raw_q, ovf_raw_d;
  logic                   overflow_q, overflow_d;
`endif

  assign w_rise = sig_s2_q & ~sig_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_COUNT;
      timer_q      <= '0;
      edge_cnt_q   <= '0;
      tens_q       <= '0;
      ten_count_q  <= '0;
      unit_count_q <= '0;
      load_q       <= 1'b0;
      sig_s1_q     <= 1'b0;
      sig_s2_q     <= 1'b0;
      sig_q        <= 1'b0;
`ifdef FREQ_OVERFLOW_EN
      ovf_raw_q    <= 1'b0;
      overflow_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      edge_cnt_q   <= edge_cnt_d;
      tens_q       <= tens_d;
      ten_count_q  <= ten_count_d;
      unit_count_q <= unit_count_d;
      load_q       <= load_d;
      sig_s1_q     <= signal;
      sig_s2_q     <= sig_s1_q;
      sig_q        <= sig_s2_q;
`ifdef FREQ_OVERFLOW_EN
      ovf_raw_q    <= ovf_raw_d;
      overflow_q   <= overflow_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    edge_cnt_d   = edge_cnt_q;
    tens_d       = tens_q;
    ten_count_d  = ten_count_q;
    unit_count_d = unit_count_q;
    load_d       = 1'b0;
`ifdef FREQ_OVERFLOW_EN
    ovf_raw_d    = ovf_raw_q;
    overflow_d   = overflow_q;
`endif
    case (state_q)
      ST_COUNT: begin
        timer_d = timer_q + c_timer_w'(1);
        // Saturate at 99 so the BCD split never needs a hundreds digit.
        if (w_rise) begin
          if (edge_cnt_q == c_cnt_max) begin
`ifdef FREQ_OVERFLOW_EN
            ovf_raw_d = 1'b1;
`endif
          end else begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
        end
        if (timer_q == c_timer_last) begin
          timer_d = '0;
          state_d = ST_TENS;
        end
      end
      ST_TENS: begin
        if (edge_cnt_q >= c_cnt_ten) begin
          edge_cnt_d = edge_cnt_q - c_cnt_ten;
          tens_d     = tens_q + 4'd1;
        end else begin
          state_d = ST_UNITS;
        end
      end
      ST_UNITS: begin
        ten_count_d  = tens_q;
        unit_count_d = edge_cnt_q[3:0];
        load_d       = 1'b1;
        edge_cnt_d   = '0;
        tens_d       = '0;
`ifdef FREQ_OVERFLOW_EN
        overflow_d   = ovf_raw_q;
        ovf_raw_d    = 1'b0;
`endif
        state_d      = ST_COUNT;
      end
      default: state_d = ST_COUNT;
    endcase
  end

  assign ten_count  = ten_count_q;
  assign unit_count = unit_count_q;
  assign load       = load_q;
`ifdef FREQ_OVERFLOW_EN
  assign overflow   = overflow_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_freq_count_fsm.sv
// ============================================================================
// Module  : tb_freq_count_fsm
// Desc    : Self-checking bench for freq_count_fsm (honours FREQ_OVERFLOW_EN).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_freq_count_fsm;

  localparam int UP = 1200;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       signal = 1'b0;
  logic [3:0] ten_count;
  logic [3:0] unit_count;
  logic       load;
`ifdef FREQ_OVERFLOW_EN
  logic       overflow;
`endif

  typedef struct packed {
    logic [3:0] ten;
    logic [3:0] unit;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  // Negedge index within the current window; index k precedes the posedge where timer==k.
  int   widx     = 0;

  freq_count_fsm #(.UPDATE_PERIOD(UP), .CNT_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .signal     (signal),
    .ten_count  (ten_count),
    .unit_count (unit_count),
    .load       (load)
`ifdef FREQ_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    widx++;
  endtask

  task automatic set_sig_at(input int idx, input logic v);
    while (widx < idx) step();
    signal = v;
  endtask

  task automatic pulses(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      set_sig_at(first + 2*i, 1'b1);
      set_sig_at(first + 2*i + 1, 1'b0);
    end
  endtask

  // Returns the window index at which load was seen (-1 on timeout) and restarts the index.
  task automatic wait_load(output int at);
    at = -1;
    for (int i = 0; i < UP + 40; i++) begin
      step();
      if (load === 1'b1) begin
        at = widx;
        break;
      end
    end
    widx = 0;
  endtask

  task automatic test_reset();
    int   at;
    bit   seen;
    exp_t e;
    reset = 1'b1;
    #2 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      signal = ~signal;
      @(negedge clk);
      if (load !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (ten_count !== 4'd0) begin n_fail++; $display("FAIL rst_ten: got %0d, expected 0", ten_count); end
    n_checks++; if (unit_count !== 4'd0) begin n_fail++; $display("FAIL rst_unit: got %0d, expected 0", unit_count); end
    n_checks++; if (seen) begin n_fail++; $display("FAIL rst_load: got load high during reset, expected 0"); end
`ifdef FREQ_OVERFLOW_EN
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %0b, expected 0", overflow); end
`endif
    signal = 1'b0;
    reset  = 1'b1;
    widx   = 0;
    sb_q.push_back('{4'd0, 4'd0, 1'b0});
    wait_load(at);
    e = sb_q.pop_front();
    n_checks++; if (at != UP + 2) begin n_fail++; $display("FAIL rst_first_load: got index %0d, expected %0d", at, UP + 2); end
    n_checks++; if (ten_count !== e.ten || unit_count !== e.unit) begin n_fail++; $display("FAIL rst_first_val: got %0d/%0d, expected %0d/%0d", ten_count, unit_count, e.ten, e.unit); end
    step();
    n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL load_width: got %0b, expected 0", load); end
  endtask

  task automatic test_count42();
    int   at;
    exp_t e;
    pulses(10, 42);
    sb_q.push_back('{4'd4, 4'd2, 1'b0});
    wait_load(at);
    e = sb_q.pop_front();
    n_checks++; if (at != UP + 6) begin n_fail++; $display("FAIL c42_latency: got index %0d, expected %0d", at, UP + 6); end
    n_checks++; if (ten_count !== e.ten || unit_count !== e.unit) begin n_fail++; $display("FAIL c42_val: got %0d/%0d, expected %0d/%0d", ten_count, unit_count, e.ten, e.unit); end
`ifdef FREQ_OVERFLOW_EN
    n_checks++; if (overflow !== e.ovf) begin n_fail++; $display("FAIL c42_ovf: got %0b, expected %0b", overflow, e.ovf); end
`endif
    step();
    n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL c42_load_width: got %0b, expected 0", load); end
  endtask

  task automatic test_stuck();
    int   at;
    exp_t e;
    // Stuck low; raise in the conversion gap so the next window sees a constant high.
    set_sig_at(UP - 2, 1'b1);
    sb_q.push_back('{4'd0, 4'd0, 1'b0});
    wait_load(at);
    e = sb_q.pop_front();
    n_checks++; if (at < 0 || ten_count !== e.ten || unit_count !== e.unit) begin n_fail++; $display("FAIL stuck_low: got %0d/%0d at %0d, expected %0d/%0d", ten_count, unit_count, at, e.ten, e.unit); end
    sb_q.push_back('{4'd0, 4'd0, 1'b0});
    wait_load(at);
    e = sb_q.pop_front();
    n_checks++; if (at != UP + 2 || ten_count !== e.ten || unit_count !== e.unit) begin n_fail++; $display("FAIL stuck_high: got %0d/%0d at %0d, expected %0d/%0d at %0d", ten_count, unit_count, at, e.ten, e.unit, UP + 2); end
    signal = 1'b0;
    pulses(4, 7);
    sb_q.push_back('{4'd0, 4'd7, 1'b0});
    wait_load(at);
    e = sb_q.pop_front();
    n_checks++; if (at < 0 || ten_count !== e.ten || unit_count !== e.unit) begin n_fail++; $display("FAIL stuck_then7: got %0d/%0d, expected %0d/%0d", ten_count, unit_count, e.ten, e.unit); end
  endtask

  task automatic test_overflow();
    int   at;
    exp_t e;
    pulses(2, 150);
    sb_q.push_back('{4'd9, 4'd9, 1'b1});
    wait_load(at);
    e = sb_q.pop_front();
    n_checks++; if (at != UP + 11) begin n_fail++; $display("FAIL sat_latency: got index %0d, expected %0d", at, UP + 11); end
    n_checks++; if (ten_count !== e.ten || unit_count !== e.unit) begin n_fail++; $display("FAIL sat_val: got %0d/%0d, expected %0d/%0d", ten_count, unit_count, e.ten, e.unit); end
`ifdef FREQ_OVERFLOW_EN
    n_checks++; if (overflow !== e.ovf) begin n_fail++; $display("FAIL sat_ovf: got %0b, expected %0b", overflow, e.ovf); end
`endif
    pulses(2, 10);
    sb_q.push_back('{4'd1, 4'd0, 1'b0});
    wait_load(at);
    e = sb_q.pop_front();
    n_checks++; if (at < 0 || ten_count !== e.ten || unit_count !== e.unit) begin n_fail++; $display("FAIL after_sat_val: got %0d/%0d, expected %0d/%0d", ten_count, unit_count, e.ten, e.unit); end
`ifdef FREQ_OVERFLOW_EN
    n_checks++; if (overflow !== e.ovf) begin n_fail++; $display("FAIL after_sat_ovf: got %0b, expected %0b", overflow, e.ovf); end
`endif
  endtask

  task automatic test_boundary();
    int   at;
    exp_t e;
    pulses(10, 9);
    // First rise lands on timer==UP-1 (counted), second on the first TENS cycle (dropped).
    set_sig_at(UP - 3, 1'b1);
    set_sig_at(UP - 2, 1'b0);
    set_sig_at(UP - 1, 1'b1);
    set_sig_at(UP,     1'b0);
    sb_q.push_back('{4'd1, 4'd0, 1'b0});
    wait_load(at);
    e = sb_q.pop_front();
    n_checks++; if (at != UP + 3) begin n_fail++; $display("FAIL edge_latency: got index %0d, expected %0d", at, UP + 3); end
    n_checks++; if (ten_count !== e.ten || unit_count !== e.unit) begin n_fail++; $display("FAIL edge_val: got %0d/%0d, expected %0d/%0d", ten_count, unit_count, e.ten, e.unit); end
    pulses(2, 23);
    sb_q.push_back('{4'd2, 4'd3, 1'b0});
    wait_load(at);
    e = sb_q.pop_front();
    n_checks++; if (at < 0 || ten_count !== e.ten || unit_count !== e.unit) begin n_fail++; $display("FAIL edge_next_val: got %0d/%0d, expected %0d/%0d", ten_count, unit_count, e.ten, e.unit); end
  endtask

  task automatic test_reset_mid();
    int   at;
    bit   seen;
    exp_t e;
    pulses(2, 95);
    set_sig_at(UP + 3, 1'b0);
    reset = 1'b0;
    #1;
    n_checks++; if (ten_count !== 4'd0 || unit_count !== 4'd0) begin n_fail++; $display("FAIL midrst_val: got %0d/%0d, expected 0/0", ten_count, unit_count); end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (load !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL midrst_load: got load high, expected 0"); end
    reset = 1'b1;
    widx  = 0;
    pulses(10, 20);
    sb_q.push_back('{4'd2, 4'd0, 1'b0});
    wait_load(at);
    e = sb_q.pop_front();
    n_checks++; if (at != UP + 4) begin n_fail++; $display("FAIL midrst_latency: got index %0d, expected %0d", at, UP + 4); end
    n_checks++; if (ten_count !== e.ten || unit_count !== e.unit) begin n_fail++; $display("FAIL midrst_after_val: got %0d/%0d, expected %0d/%0d", ten_count, unit_count, e.ten, e.unit); end
  endtask

  initial begin
    test_reset();
    test_count42();
    test_stuck();
    test_overflow();
    test_boundary();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
